// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one registered bitwise ALU among NREQ requesters.
// Requests are accepted in IDLE, computed in EXEC and held in RESP until the consumer takes them.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [ID_W-1:0]       rsp_id,
  output logic [7:0]            op_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AND   = 2'b00,
    OP_OR    = 2'b01,
    OP_XOR   = 2'b10,
    OP_NOT_A = 2'b11
  } alu_op_e;

  state_e            state_q,     state_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;
  logic [1:0]        sel_q,       sel_d;
  logic [ID_W-1:0]   id_q,        id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_y_q,     rsp_y_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [7:0]        op_count_q,  op_count_d;
  logic              busy_q,      busy_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [WIDTH-1:0]  alu_y;

  // Index reached by stepping 'step' places forward from 'base', wrapping at NREQ.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base,
                                                input int unsigned     step);
    int unsigned s;
    s = 32'(base) + step;
    s = s % unsigned'(NREQ);
    return ID_W'(s);
  endfunction

  function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       sel);
    logic [WIDTH-1:0] y;
    unique case (alu_op_e'(sel))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT_A: y = ~a;
    endcase
    return y;
  endfunction

  // Search starts at rr_ptr so the most recently served requester goes last.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
      if (!win_found && req_valid[rot_idx(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rot_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == ST_IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign alu_y = alu_eval(a_q, b_q, sel_q);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      ST_IDLE: begin
        // The winner always sees ready, so a winner means a handshake this cycle.
        if (win_found) begin
          a_d      = req_a[win_idx*WIDTH +: WIDTH];
          b_d      = req_b[win_idx*WIDTH +: WIDTH];
          sel_d    = req_sel[win_idx*2 +: 2];
          id_d     = win_idx;
          rr_ptr_d = rot_idx(win_idx, 1);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_y_d     = alu_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // busy is registered alongside the state so it never glitches on req_valid.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the captured operand registers are reset too; they are a handful of flops, not a memory array.
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the shared ALU.
module tb_alu_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [ID_W-1:0]       rsp_id;
  logic [7:0]            op_count;
  logic                  busy;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .op_count  (op_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Per-bit truth arithmetic rather than the bitwise operators.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       s);
    logic [WIDTH-1:0] res;
    for (int j = 0; j < WIDTH; j++) begin
      int x;
      int y;
      int r;
      x = int'(a[j]);
      y = int'(b[j]);
      case (s)
        2'd0:    r = x * y;
        2'd1:    r = x + y - x * y;
        2'd2:    r = (x + y) % 2;
        default: r = 1 - x;
      endcase
      res[j] = r[0];
    end
    return res;
  endfunction

  bit               m_out;
  bit               m_vis;
  int               m_ptr;
  int               m_cnt;
  int               m_id;
  int               pend_id;
  logic [WIDTH-1:0] m_y;
  logic [WIDTH-1:0] pend_y;
  int               m_w;

  always_comb m_w = winner(req_valid, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out <= 1'b0;
      m_vis <= 1'b0;
      m_ptr <= 0;
      m_cnt <= 0;
      m_id  <= 0;
      m_y   <= '0;
    end else if (!m_out) begin
      if (m_w >= 0) begin
        m_out   <= 1'b1;
        pend_id <= m_w;
        pend_y  <= alu_ref(req_a[m_w*WIDTH +: WIDTH], req_b[m_w*WIDTH +: WIDTH], req_sel[m_w*2 +: 2]);
        m_ptr   <= (m_w + 1) % NREQ;
      end
    end else if (!m_vis) begin
      m_vis <= 1'b1;
      m_y   <= pend_y;
      m_id  <= pend_id;
    end else if (rsp_ready) begin
      m_vis <= 1'b0;
      m_out <= 1'b0;
      m_cnt <= (m_cnt + 1) % 256;
    end
  end

  logic [NREQ-1:0] exp_rdy;

  always @(negedge clk) begin
    exp_rdy = (!rst && !m_out && m_w >= 0) ? NREQ'(1 << m_w) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_vis));
    check("rsp_y",     32'(rsp_y),     32'(m_y));
    check("rsp_id",    32'(rsp_id),    m_id);
    check("op_count",  32'(op_count),  m_cnt);
    check("busy",      32'(busy),      32'(m_out));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] s, output logic [WIDTH-1:0] y, output logic [ID_W-1:0] id);
    int guard;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
    req_sel[r*2 +: 2]       = s;
    #1;
    guard = 0;
    while (!req_ready[r] && guard < 20) begin
      tick();
      guard++;
    end
    check("op_grant", 32'(req_ready[r]), 32'd1);
    tick();
    req_valid = '0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("op_rsp_valid", 32'(rsp_valid), 32'd1);
    y  = rsp_y;
    id = rsp_id;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  localparam logic [WIDTH-1:0] SWEEP_Y [4] = '{4'b0001, 4'b0111, 4'b0110, 4'b1010};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] y;
    logic [ID_W-1:0]  id;
    logic [NREQ-1:0]  grant_oh [6];
    int               grant_cyc [6];
    logic [ID_W-1:0]  rid [6];
    int               ng;
    int               nr;
    int               c;
    int               n_ops;
    logic [NREQ-1:0]  acc;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    repeat (3) tick();
    req_valid = '0;
    rst       = 1'b0;
    #1 check("post_rst_idle_ready", 32'(req_ready), 32'd0);

    // Single op from requester 2
    tick();
    req_valid = 4'b0100;
    req_a[8 +: 4] = 4'b1100;
    req_b[8 +: 4] = 4'b1010;
    req_sel[4 +: 2] = 2'b00;
    #1 check("single_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_exec_busy",  32'(busy),      32'd1);
    check("single_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_y",     32'(rsp_y),     32'b1000);
    check("single_rsp_id",    32'(rsp_id),    32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("single_done_valid", 32'(rsp_valid), 32'd0);
    check("single_op_count",   32'(op_count),  32'd1);

    // Opcode sweep on requester 1
    for (int s = 0; s < 4; s++) begin
      do_op(1, 4'b0101, 4'b0011, 2'(s), y, id);
      check("sweep_y",  32'(y),  32'(SWEEP_Y[s]));
      check("sweep_id", 32'(id), 32'd1);
    end

    // Backpressure with NOT a on requester 0
    req_valid = 4'b0001;
    req_a[0 +: 4] = 4'b0110;
    req_b[0 +: 4] = 4'b1111;
    req_sel[0 +: 2] = 2'b11;
    #1 check("bp_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b1110;
    req_a[4 +: 4] = 4'b1111;
    req_b[4 +: 4] = 4'b0000;
    req_sel[2 +: 2] = 2'b01;
    req_a[15:8] = 8'($urandom);
    req_b[15:8] = 8'($urandom);
    req_sel[7:4] = 4'($urandom);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_y",     32'(rsp_y),     32'b1001);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy",  32'(busy),      32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    check("bp_done_busy",  32'(busy),      32'd0);
    tick();
    req_valid = '0;
    tick();
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);

    // Asynchronous reset in the middle of RESP
    #2 rst = 1'b1;
    req_valid = '1;
    #1;
    check("midrst_valid",    32'(rsp_valid), 32'd0);
    check("midrst_y",        32'(rsp_y),     32'd0);
    check("midrst_id",       32'(rsp_id),    32'd0);
    check("midrst_op_count", 32'(op_count),  32'd0);
    check("midrst_busy",     32'(busy),      32'd0);
    check("midrst_ready",    32'(req_ready), 32'd0);
    tick();
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1 check("midrst_idle_ready", 32'(req_ready), 32'd0);

    // Round-robin with everyone requesting and rsp_ready tied high
    req_a   = 16'($urandom);
    req_b   = 16'($urandom);
    req_sel = 8'($urandom);
    req_valid = '1;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    c  = 0;
    while (nr < 6 && c < 40) begin
      #1;
      if (req_ready != '0 && ng < 6) begin
        grant_oh[ng]  = req_ready;
        grant_cyc[ng] = c;
        ng++;
      end
      if (rsp_valid && rsp_ready && nr < 6) begin
        rid[nr] = rsp_id;
        nr++;
      end
      tick();
      if (ng == 6) req_valid = '0;
      c++;
    end
    check("rr_grant_count", ng, 6);
    check("rr_rsp_count",   nr, 6);
    for (int k = 0; k < ng; k++) begin
      check("rr_order", 32'(grant_oh[k]), 32'(1 << (k % NREQ)));
      if (k > 0) check("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
    end
    for (int k = 0; k < nr; k++) check("rr_rsp_id", 32'(rid[k]), k % NREQ);
    rsp_ready = 1'b0;

    // Randomized traffic; requesters hold valid+payload until accepted
    acc = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_sel[i*2 +: 2]       = 2'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      acc = req_valid & req_ready;
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    rsp_ready = 1'b0;

    // Counter wrap: bring the count to 255, then complete one more op
    n_ops = (255 - m_cnt + 256) % 256;
    for (int k = 0; k < n_ops; k++) begin
      do_op(k % NREQ, WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), y, id);
    end
    req_valid = 4'b1000;
    req_a[12 +: 4] = 4'b0011;
    req_b[12 +: 4] = 4'b0101;
    req_sel[6 +: 2] = 2'b10;
    #1 check("wrap_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    check("wrap_rsp_y",  32'(rsp_y),    32'b0110);
    check("wrap_pre",    32'(op_count), 32'd255);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1 check("wrap_post", 32'(op_count), 32'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
